// File: rtl/lsu_byte_master.sv
// ============================================================================
// Module   : lsu_byte_master
// Brief    : CPU load/store initiator splitting word/half/byte accesses into
//            big-endian single-byte req/ack transactions; load data extended.
// Options  : LSU_MISALIGN_TRAP_EN - trap misaligned half/word with err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    input  logic              Memhalf,
    input  logic              Membyte,
    input  logic              MemExt,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rd,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd,
    input  logic              mem_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_we;
    logic              r_ext;
    logic [1:0]        r_last;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wd;
    logic [31:0]       r_asm;
    logic [31:0]       r_rd;

    logic [1:0]        w_last;
    logic [ADDR_W-1:0] w_base;
    logic [1:0]        w_pos;
    logic              w_hs;
    logic              w_last_hs;
    logic [31:0]       w_ext;
    logic              w_misalign;
    logic              w_trap;

    // r_last holds byte count minus one; Memhalf wins over Membyte
    assign w_last = Memhalf ? 2'd1 : (Membyte ? 2'd0 : 2'd3);
    assign w_base = Memhalf ? {addr[ADDR_W-1:1], 1'b0} :
                    (Membyte ? addr : {addr[ADDR_W-1:2], 2'b00});

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;

    assign w_misalign = (Memhalf & addr[0]) | (~Memhalf & ~Membyte & (|addr[1:0]));
    assign w_trap     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == c_IDLE && req) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign w_trap     = 1'b0;
`endif

    // Byte k lands at position (count-1-k) from the LSB: big-endian order
    assign w_pos     = r_last - r_k;
    assign w_hs      = (r_state == c_XFER) & mem_ack;
    assign w_last_hs = w_hs & (r_k == r_last);

    always_comb begin
        w_ext = r_asm;
        case (r_last)
            2'd0:    w_ext = {{24{r_ext & r_asm[7]}},  r_asm[7:0]};
            2'd1:    w_ext = {{16{r_ext & r_asm[15]}}, r_asm[15:0]};
            default: w_ext = r_asm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (req) w_state_nxt = w_misalign ? c_DONE : c_XFER;
            c_XFER:  if (w_last_hs) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != c_IDLE);
        done     = (r_state == c_DONE);
        mem_req  = (r_state == c_XFER);
        mem_we   = mem_req & r_we;
        err      = done & w_trap;
        mem_addr = r_base + ADDR_W'(r_k);
        mem_wd   = r_wd[{w_pos, 3'b000} +: 8];
        // Load result is visible in the done cycle itself, then held in r_rd
        rd       = (done & ~r_we & ~w_trap) ? w_ext : r_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_ext  <= 1'b0;
            r_last <= 2'd0;
            r_k    <= 2'd0;
            r_base <= '0;
            r_wd   <= 32'd0;
            r_asm  <= 32'd0;
            r_rd   <= 32'd0;
        end else begin
            if (r_state == c_IDLE && req) begin
                r_we   <= we;
                r_ext  <= MemExt;
                r_last <= w_last;
                r_k    <= 2'd0;
                r_base <= w_base;
                r_wd   <= wd;
                r_asm  <= 32'd0;
            end
            if (w_hs) begin
                r_k                         <= r_k + 2'd1;
                r_asm[{w_pos, 3'b000} +: 8] <= mem_rd;
            end
            if (r_state == c_DONE && !r_we && !w_trap) begin
                r_rd <= w_ext;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
// ============================================================================
// Module   : tb_lsu_byte_master
// Brief    : Self-checking bench for lsu_byte_master with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        Memhalf;
    logic        Membyte;
    logic        MemExt;
    logic        busy;
    logic        done;
    logic [31:0] rd;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;
    logic        mem_ack;

    logic [7:0]  mem [256];
    logic [31:0] exp_rd;
    int          checks;
    int          errors;

    lsu_byte_master #(.ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .Memhalf  (Memhalf),
        .Membyte  (Membyte),
        .MemExt   (MemExt),
        .busy     (busy),
        .done     (done),
        .rd       (rd),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One CPU access. ack_mode: 0 ack tied high, 1 random ack, 2 stall byte 2 for 3 cycles.
    // exp_lat > 0 additionally pins the done cycle relative to the accept cycle.
    task automatic access(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wd,
                          input logic t_half, input logic t_byte, input logic t_ext,
                          input int ack_mode, input int exp_lat);
        int          n;
        int          k;
        int          cyc;
        int          waits;
        int          stall;
        logic [31:0] base;
        logic [31:0] val;
        logic [31:0] new_rd;
        logic        trap;
        logic        seen_done;

        n    = t_half ? 2 : (t_byte ? 1 : 4);
        base = t_half ? (t_addr & ~32'd1) : (t_byte ? t_addr : (t_addr & ~32'd3));
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (n == 2 && t_addr[0]) || (n == 4 && t_addr[1:0] != 2'b00);
`endif
        val = 32'd0;
        for (int i = 0; i < n; i++) val = (val << 8) | 32'(mem[8'(base + 32'(i))]);
        if (t_ext && n == 2 && val[15]) val = val | 32'hFFFF_0000;
        if (t_ext && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
        new_rd = (t_we || trap) ? exp_rd : val;

        @(posedge clk); #1;
        req = 1'b1; we = t_we; addr = t_addr; wd = t_wd;
        Memhalf = t_half; Membyte = t_byte; MemExt = t_ext;
        k = 0; cyc = 0; waits = 0; stall = 0; seen_done = 1'b0;

        while (!seen_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ack_mode == 0) mem_ack = 1'b1;
            else if (ack_mode == 2) begin
                if (k == 2 && stall < 3) begin mem_ack = 1'b0; stall++; end
                else mem_ack = 1'b1;
            end else mem_ack = ($urandom_range(0, 3) != 0);
            mem_rd = mem_ack ? mem[8'(base + 32'(k))] : 8'($urandom);
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            if (done) begin
                seen_done = 1'b1;
                req = 1'b0;
            end else begin
                chk("rd_hold", rd, exp_rd);
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, base + 32'(k));
                chk("mem_we", 32'(mem_we), 32'(t_we));
                if (t_we && k < n) chk("mem_wd", 32'(mem_wd), (t_wd >> (8 * (n - 1 - k))) & 32'hFF);
                if (mem_ack) begin
                    if (t_we) mem[8'(base + 32'(k))] = mem_wd;
                    k++;
                end else waits++;
            end
        end

        chk("timeout", 32'(seen_done), 32'd1);
        chk("done_mem_req", 32'(mem_req), 32'd0);
        chk("bytes", 32'(k), trap ? 32'd0 : 32'(n));
        chk("done_cycle", 32'(cyc), trap ? 32'd1 : 32'(1 + n + waits));
        if (exp_lat > 0) chk("latency", 32'(cyc), trap ? 32'd1 : 32'(exp_lat));
        chk("err", 32'(err), 32'(trap));
        chk("rd", rd, new_rd);
        exp_rd = new_rd;

        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("rd_held", rd, exp_rd);
    endtask

    initial begin
        logic [7:0] old41;
        logic [1:0] sz;
        checks = 0; errors = 0; exp_rd = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0;
        Memhalf = 1'b0; Membyte = 1'b0; MemExt = 1'b0; mem_rd = 8'd0; mem_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", 32'(mem_wd), 32'd0);
        rst = 1'b0;

        // Word store to a misaligned address, ack tied high
        access(1'b1, 32'h103, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 0, 5);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("ws_0x100", 32'(mem[8'h00]), 32'hDE);
        chk("ws_0x103", 32'(mem[8'h03]), 32'hEF);
`endif

        mem[8'h20] = 8'h80; mem[8'h21] = 8'h01;
        access(1'b0, 32'h21, 32'd0, 1'b1, 1'b0, 1'b1, 0, 3);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("half_sext", rd, 32'hFFFF_8001);
`endif
        access(1'b0, 32'h21, 32'd0, 1'b1, 1'b0, 1'b0, 0, 3);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("half_zext", rd, 32'h0000_8001);
`endif

        mem[8'h07] = 8'h7F;
        access(1'b0, 32'h7, 32'd0, 1'b0, 1'b1, 1'b1, 0, 2);
        chk("byte_pos", rd, 32'h0000_007F);
        mem[8'h07] = 8'hF0;
        access(1'b0, 32'h7, 32'd0, 1'b0, 1'b1, 1'b1, 0, 2);
        chk("byte_neg", rd, 32'hFFFF_FFF0);

        mem[8'h30] = 8'h12; mem[8'h31] = 8'h9A; mem[8'h32] = 8'h56; mem[8'h33] = 8'h78;
        access(1'b0, 32'h30, 32'd0, 1'b0, 1'b0, 1'b1, 2, 8);
        chk("word_stall", rd, 32'h129A_5678);

        // Reset during byte 1 of a word store
        mem[8'h40] = 8'h00; mem[8'h41] = 8'h5A; old41 = 8'h5A;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h40; wd = 32'h1122_3344;
        Memhalf = 1'b0; Membyte = 1'b0; MemExt = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("rst_t_addr0", mem_addr, 32'h40);
        chk("rst_t_wd0", 32'(mem_wd), 32'h11);
        if (mem_req && mem_ack && mem_we) mem[8'h40] = mem_wd;
        @(posedge clk); #1;
        mem_ack = 1'b0; rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_t_addr1", mem_addr, 32'h41);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_t_busy", 32'(busy), 32'd0);
        chk("rst_t_mem_req", 32'(mem_req), 32'd0);
        chk("rst_t_done", 32'(done), 32'd0);
        chk("rst_t_rd", rd, 32'd0);
        chk("rst_t_byte0", 32'(mem[8'h40]), 32'h11);
        chk("rst_t_byte1", 32'(mem[8'h41]), 32'(old41));
        exp_rd = 32'd0;
        access(1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0, 0, 5);

`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 32'h2, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1);
`endif

        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), $urandom, $urandom,
                   sz[0], sz[1], 1'($urandom_range(0, 1)), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
